// File: rtl/s_axi4l_reg_pkg.sv
// s_axi4l_reg_pkg: word-index map and shared types for the AXI4-Lite register file.
// Revision: 1.0
`default_nettype none

package s_axi4l_reg_pkg;

  localparam int unsigned REG_CTRL     = 0;
  localparam int unsigned REG_STATUS   = 1;
  localparam int unsigned REG_IRQ_STAT = 2;
  localparam int unsigned REG_IRQ_MASK = 3;
  localparam int unsigned REG_GP_BASE  = 4;

  localparam int unsigned IDX_WIDTH = 6;
  typedef logic [IDX_WIDTH-1:0] reg_idx_t;

  function automatic logic idx_in_range(input logic [31:0] idx,
                                        input int unsigned lo,
                                        input int unsigned n);
    return (idx >= lo) && (idx < lo + n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/s_axi4l_w1c_reg.sv
// s_axi4l_w1c_reg: event-set / write-1-clear register; a set and clear on the same bit keeps it set.
// Revision: 1.0
`default_nettype none

module s_axi4l_w1c_reg #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] set_pulse,
  input  logic [WIDTH-1:0] clr_mask,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else begin
      q <= (q & ~clr_mask) | set_pulse;
    end
  end

endmodule

`default_nettype wire

// File: rtl/s_axi4l_reg_file.sv
// s_axi4l_reg_file: CTRL/STATUS/IRQ_STAT/IRQ_MASK plus NUM_GP general registers behind a
// strobe write port and a one-cycle registered read port. Revision: 1.0
`default_nettype none

module s_axi4l_reg_file
  import s_axi4l_reg_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 8,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    NUM_GP     = 4,
  parameter logic [DATA_WIDTH-1:0] PULSE_MASK = 'h1
) (
  input  logic                         i_axi_clock,
  input  logic                         i_reset,
  input  logic [ADDR_WIDTH-1:0]        i_waddr,
  input  logic [DATA_WIDTH-1:0]        i_wdata,
  input  logic                         i_wvalid,
  output logic                         o_werr,
  input  logic [ADDR_WIDTH-1:0]        i_raddr,
  input  logic                         i_rvalid,
  output logic [DATA_WIDTH-1:0]        o_rdata,
  output logic                         o_rdata_valid,
  output logic                         o_rerr,
  input  logic [DATA_WIDTH-1:0]        i_status,
  input  logic [DATA_WIDTH-1:0]        i_irq_set,
  output logic [DATA_WIDTH-1:0]        o_ctrl,
  output logic                         o_irq,
  output logic [NUM_GP*DATA_WIDTH-1:0] o_gp
);

  logic [31:0]           widx;
  logic [31:0]           ridx;
  logic                  wr_ctrl;
  logic                  wr_stat;
  logic                  wr_mask;
  logic                  wr_gp;
  logic                  wr_bad;
  logic [DATA_WIDTH-1:0] ctrl_q;
  logic [DATA_WIDTH-1:0] mask_q;
  logic [DATA_WIDTH-1:0] irq_stat;
  logic [DATA_WIDTH-1:0] stat_clr;
  logic [DATA_WIDTH-1:0] gp_q [NUM_GP];
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_err;
  logic                  unused_addr_bits;

  // Byte-lane bits are not part of the word index.
  assign unused_addr_bits = ^{i_waddr[1:0], i_raddr[1:0]};
  assign widx = 32'(i_waddr[ADDR_WIDTH-1:2]);
  assign ridx = 32'(i_raddr[ADDR_WIDTH-1:2]);

  assign wr_ctrl  = i_wvalid && (widx == REG_CTRL);
  assign wr_stat  = i_wvalid && (widx == REG_IRQ_STAT);
  assign wr_mask  = i_wvalid && (widx == REG_IRQ_MASK);
  assign wr_gp    = i_wvalid && idx_in_range(widx, REG_GP_BASE, NUM_GP);
  assign wr_bad   = i_wvalid && !(wr_ctrl || wr_stat || wr_mask || wr_gp);
  assign stat_clr = wr_stat ? i_wdata : '0;

  always_ff @(posedge i_axi_clock) begin
    if (i_reset) begin
      ctrl_q <= '0;
      mask_q <= '0;
      o_werr <= 1'b0;
      o_irq  <= 1'b0;
    end else begin
      // Pulse bits live for exactly the cycle after the write that set them.
      ctrl_q <= wr_ctrl ? i_wdata : (ctrl_q & ~PULSE_MASK);
      if (wr_mask) begin
        mask_q <= i_wdata;
      end
      o_werr <= wr_bad;
      o_irq  <= |(irq_stat & mask_q);
    end
  end

  always_ff @(posedge i_axi_clock) begin
    for (int k = 0; k < NUM_GP; k++) begin
      if (i_reset) begin
        gp_q[k] <= '0;
      end else if (wr_gp && (widx == REG_GP_BASE + k)) begin
        gp_q[k] <= i_wdata;
      end
    end
  end

  s_axi4l_w1c_reg #(
    .WIDTH(DATA_WIDTH)
  ) u_irq_stat (
    .clk      (i_axi_clock),
    .rst      (i_reset),
    .set_pulse(i_irq_set),
    .clr_mask (stat_clr),
    .q        (irq_stat)
  );

  for (genvar g = 0; g < NUM_GP; g++) begin : g_gp_out
    assign o_gp[g*DATA_WIDTH +: DATA_WIDTH] = gp_q[g];
  end

  assign o_ctrl = ctrl_q;

  always_comb begin
    rd_data = '0;
    rd_err  = 1'b0;
    if (ridx == REG_CTRL) begin
      rd_data = ctrl_q;
    end else if (ridx == REG_STATUS) begin
      rd_data = i_status;
    end else if (ridx == REG_IRQ_STAT) begin
      rd_data = irq_stat;
    end else if (ridx == REG_IRQ_MASK) begin
      rd_data = mask_q;
    end else if (idx_in_range(ridx, REG_GP_BASE, NUM_GP)) begin
      for (int k = 0; k < NUM_GP; k++) begin
        if (ridx == REG_GP_BASE + k) begin
          rd_data = gp_q[k];
        end
      end
    end else begin
      rd_err = 1'b1;
    end
  end

  // Sampling the pre-edge register values gives read-old on a same-cycle collision.
  always_ff @(posedge i_axi_clock) begin
    if (i_reset) begin
      o_rdata       <= '0;
      o_rdata_valid <= 1'b0;
      o_rerr        <= 1'b0;
    end else begin
      o_rdata_valid <= i_rvalid;
      if (i_rvalid) begin
        o_rdata <= rd_data;
        o_rerr  <= rd_err;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_s_axi4l_reg_file.sv
// tb_s_axi4l_reg_file: directed self-checking bench for s_axi4l_reg_file.
// Revision: 1.0
`default_nettype none

module tb_s_axi4l_reg_file;

  localparam int AW = 8;
  localparam int DW = 32;
  localparam int NG = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [AW-1:0]  waddr;
  logic [DW-1:0]  wdata;
  logic           wvalid;
  logic           werr;
  logic [AW-1:0]  raddr;
  logic           rvalid;
  logic [DW-1:0]  rdata;
  logic           rdata_valid;
  logic           rerr;
  logic [DW-1:0]  status;
  logic [DW-1:0]  irq_set;
  logic [DW-1:0]  ctrl;
  logic           irq;
  logic [NG*DW-1:0] gp;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  s_axi4l_reg_file #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .NUM_GP    (NG),
    .PULSE_MASK(32'h0000_0001)
  ) dut (
    .i_axi_clock  (clk),
    .i_reset      (rst),
    .i_waddr      (waddr),
    .i_wdata      (wdata),
    .i_wvalid     (wvalid),
    .o_werr       (werr),
    .i_raddr      (raddr),
    .i_rvalid     (rvalid),
    .o_rdata      (rdata),
    .o_rdata_valid(rdata_valid),
    .o_rerr       (rerr),
    .i_status     (status),
    .i_irq_set    (irq_set),
    .o_ctrl       (ctrl),
    .o_irq        (irq),
    .o_gp         (gp)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    waddr  = a;
    wdata  = d;
    wvalid = 1'b1;
    tick();
    wvalid = 1'b0;
  endtask

  task automatic do_read(input logic [AW-1:0] a, input logic [DW-1:0] exp_d,
                         input logic exp_e, input string tag);
    raddr  = a;
    rvalid = 1'b1;
    tick();
    rvalid = 1'b0;
    check({tag, "_valid"}, 128'(rdata_valid), 128'(1'b1));
    check({tag, "_data"}, 128'(rdata), 128'(exp_d));
    check({tag, "_err"}, 128'(rerr), 128'(exp_e));
  endtask

  initial begin
    rst = 1'b1; waddr = 8'h10; wdata = 32'hFFFF_FFFF; wvalid = 1'b1;
    raddr = 8'h00; rvalid = 1'b1; status = 32'h0; irq_set = 32'hFFFF_FFFF;

    // 1: reset dominates concurrent writes, reads and events
    repeat (3) tick();
    check("rst_gp", 128'(gp), 128'(0));
    check("rst_ctrl", 128'(ctrl), 128'(0));
    check("rst_irq", 128'(irq), 128'(0));
    check("rst_werr", 128'(werr), 128'(0));
    check("rst_rvalid", 128'(rdata_valid), 128'(0));
    check("rst_rdata", 128'(rdata), 128'(0));
    rst = 1'b0; wvalid = 1'b0; rvalid = 1'b0; irq_set = 32'h0;
    for (int i = 0; i < 8; i++) begin
      do_read(AW'(i * 4), 32'h0, 1'b0, $sformatf("rst_rd%0d", i));
    end

    // 2: GP write and read latency
    do_write(8'h10, 32'hDEAD_BEEF);
    check("gp0_out", 128'(gp[31:0]), 128'(32'hDEAD_BEEF));
    check("gp0_werr", 128'(werr), 128'(0));
    do_read(8'h10, 32'hDEAD_BEEF, 1'b0, "gp0_rd");
    tick();
    check("rvalid_drop", 128'(rdata_valid), 128'(0));
    check("rdata_hold", 128'(rdata), 128'(32'hDEAD_BEEF));
    do_read(8'h13, 32'hDEAD_BEEF, 1'b0, "lane_ign");
    do_write(8'h1C, 32'hCAFE_0007);
    check("gp3_out", 128'(gp[127:96]), 128'(32'hCAFE_0007));

    // 3: CTRL pulse bit
    do_write(8'h00, 32'h0000_0003);
    check("ctrl_pulse", 128'(ctrl), 128'(32'h3));
    tick();
    check("ctrl_held1", 128'(ctrl), 128'(32'h2));
    tick();
    check("ctrl_held2", 128'(ctrl), 128'(32'h2));

    // 4: interrupts
    do_write(8'h0C, 32'h0000_0004);
    irq_set = 32'h4;
    tick();
    irq_set = 32'h0;
    check("irq_pre", 128'(irq), 128'(0));
    tick();
    check("irq_set", 128'(irq), 128'(1));
    irq_set = 32'h4;
    do_write(8'h08, 32'h0000_0004);
    irq_set = 32'h0;
    tick();
    check("irq_setwins", 128'(irq), 128'(1));
    do_read(8'h08, 32'h4, 1'b0, "stat_keep");
    do_write(8'h08, 32'h0000_0004);
    tick();
    check("irq_clr", 128'(irq), 128'(0));
    irq_set = 32'h1;
    tick();
    irq_set = 32'h0;
    tick();
    tick();
    check("irq_masked", 128'(irq), 128'(0));
    do_read(8'h08, 32'h1, 1'b0, "stat_unmasked");

    // 5: error handling
    status = 32'h1234_5678;
    do_write(8'h04, 32'hFFFF_FFFF);
    check("werr_status", 128'(werr), 128'(1));
    tick();
    check("werr_pulse", 128'(werr), 128'(0));
    do_read(8'h04, 32'h1234_5678, 1'b0, "status_rd");
    do_read(8'hFC, 32'h0, 1'b1, "unmapped_rd");
    do_write(8'h20, 32'h5555_5555);
    check("werr_unmapped", 128'(werr), 128'(1));
    check("gp_untouched", 128'(gp), {32'hCAFE_0007, 32'h0, 32'h0, 32'hDEAD_BEEF});

    // 6: same-index read/write collision returns the old value
    do_write(8'h14, 32'h0000_0005);
    waddr = 8'h14; wdata = 32'h1; wvalid = 1'b1;
    raddr = 8'h14; rvalid = 1'b1;
    tick();
    wvalid = 1'b0; rvalid = 1'b0;
    check("coll_old", 128'(rdata), 128'(32'h5));
    check("coll_gp", 128'(gp[63:32]), 128'(32'h1));
    do_read(8'h14, 32'h1, 1'b0, "coll_new");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
